// File: rtl/tfe_move_ctrl.sv
// 2048 move sequencer: owns the 4x4 board, slides one line per cycle, spawns a tile, then checks for game over.
// Define TFE_BOARD_LOAD_EN to add the load_valid/load_board direct board-load port.
module tfe_move_ctrl #(
    parameter int          TILE_W  = 4,
    parameter int          WIN_EXP = 11,
    parameter logic [15:0] SEED    = 16'hACE1,
    parameter int          SCORE_W = 20
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 move_valid,
    input  logic [1:0]           move_dir,
`ifdef TFE_BOARD_LOAD_EN
    input  logic                 load_valid,
    input  logic [16*TILE_W-1:0] load_board,
`endif
    output logic                 move_ready,
    output logic                 move_done,
    output logic                 moved,
    output logic [16*TILE_W-1:0] board,
    output logic [SCORE_W-1:0]   score,
    output logic                 game_over,
    output logic                 win
);

    typedef enum logic [2:0] {S_INIT, S_IDLE, S_SLIDE, S_SPAWN, S_CHECK, S_OVER} state_t;

    localparam logic [TILE_W-1:0] WIN_E = TILE_W'(WIN_EXP);
    localparam logic [TILE_W-1:0] EMPTY = '0;

    state_t                  state;
    logic [15:0][TILE_W-1:0] cells;
    logic [15:0]             lfsr;
    logic [1:0]              dir_q;
    logic [1:0]              line_q;
    logic                    changed;
    logic                    probing;
    logic                    init_second;
    logic [3:0]              spawn_idx;

    assign board = cells;

    // Cell index of element i of the selected line, with element 0 sitting on the edge the tiles move toward.
    function automatic logic [3:0] cell_pos(input logic [1:0] dir, input logic [1:0] line, input logic [1:0] i);
        case (dir)
            2'd0:    cell_pos = {line, i};
            2'd1:    cell_pos = {line, ~i};
            2'd2:    cell_pos = {i, line};
            default: cell_pos = {~i, line};
        endcase
    endfunction

    logic [3:0]        pos    [4];
    logic [TILE_W-1:0] ln     [4];
    logic [TILE_W-1:0] merged [4];
    logic [17:0]       line_add;
    logic              line_win;
    logic              line_diff;

    always_comb begin
        logic [TILE_W-1:0] cmp [5];
        logic [TILE_W-1:0] nexp;
        logic [2:0]        k;
        logic              skip;

        for (int i = 0; i < 4; i++) begin
            pos[i]    = cell_pos(dir_q, line_q, 2'(i));
            ln[i]     = cells[pos[i]];
            merged[i] = EMPTY;
        end
        for (int i = 0; i < 5; i++) cmp[i] = EMPTY;

        k = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (ln[i] != EMPTY) begin
                cmp[k] = ln[i];
                k      = k + 3'd1;
            end
        end

        // cmp[4] stays empty, so the last real tile never finds a partner past the end.
        k        = 3'd0;
        skip     = 1'b0;
        nexp     = EMPTY;
        line_add = '0;
        line_win = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (cmp[i] != EMPTY) begin
                if (cmp[i] == cmp[i+1]) begin
                    nexp     = (cmp[i] == '1) ? cmp[i] : cmp[i] + TILE_W'(1);
                    line_add = line_add + (18'd1 << nexp);
                    if (nexp == WIN_E) line_win = 1'b1;
                    skip     = 1'b1;
                end else begin
                    nexp = cmp[i];
                end
                merged[k[1:0]] = nexp;
                k              = k + 3'd1;
            end
        end

        line_diff = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (merged[i] != ln[i]) line_diff = 1'b1;
        end
    end

    logic [SCORE_W:0]   score_sum;
    logic [SCORE_W-1:0] score_next;

    assign score_sum  = {1'b0, score} + (SCORE_W+1)'(line_add);
    assign score_next = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    logic [3:0]        cand;
    logic              cand_empty;
    logic [TILE_W-1:0] spawn_val;

    assign cand       = probing ? spawn_idx : lfsr[3:0];
    assign cand_empty = (cells[cand] == EMPTY);
    assign spawn_val  = (lfsr[7:4] == 4'd0) ? TILE_W'(2) : TILE_W'(1);

    logic full;
    logic pair;

    always_comb begin
        full = 1'b1;
        pair = 1'b0;
        for (int c = 0; c < 16; c++) begin
            if (cells[c] == EMPTY) full = 1'b0;
        end
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (cells[r*4+c] == cells[r*4+c+1]) pair = 1'b1;
            end
        end
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (cells[r*4+c] == cells[(r+1)*4+c]) pair = 1'b1;
            end
        end
    end

    logic                 load_hit;
    logic [16*TILE_W-1:0] load_cells;

`ifdef TFE_BOARD_LOAD_EN
    assign load_hit   = load_valid && (state == S_IDLE || state == S_OVER);
    assign load_cells = load_board;
`else
    assign load_hit   = 1'b0;
    assign load_cells = '0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_INIT;
            cells       <= '0;
            lfsr        <= SEED;
            dir_q       <= 2'd0;
            line_q      <= 2'd0;
            changed     <= 1'b0;
            probing     <= 1'b0;
            init_second <= 1'b0;
            spawn_idx   <= 4'd0;
            score       <= '0;
            game_over   <= 1'b0;
            win         <= 1'b0;
            move_ready  <= 1'b0;
            move_done   <= 1'b0;
            moved       <= 1'b0;
        end else begin
            lfsr       <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            move_done  <= 1'b0;
            move_ready <= 1'b0;
            if (load_hit) begin
                cells      <= load_cells;
                score      <= '0;
                game_over  <= 1'b0;
                win        <= 1'b0;
                state      <= S_IDLE;
                move_ready <= 1'b1;
            end else begin
                case (state)
                    // INIT reuses the spawn probe twice before handing over to IDLE.
                    S_INIT, S_SPAWN: begin
                        if (cand_empty) begin
                            cells[cand] <= spawn_val;
                            probing     <= 1'b0;
                            if (state == S_SPAWN) begin
                                state <= S_CHECK;
                            end else if (init_second) begin
                                state      <= S_IDLE;
                                move_ready <= 1'b1;
                            end else begin
                                init_second <= 1'b1;
                            end
                        end else begin
                            spawn_idx <= cand + 4'd1;
                            probing   <= 1'b1;
                        end
                    end
                    S_IDLE: begin
                        if (move_valid && move_ready) begin
                            dir_q   <= move_dir;
                            line_q  <= 2'd0;
                            changed <= 1'b0;
                            state   <= S_SLIDE;
                        end else begin
                            move_ready <= 1'b1;
                        end
                    end
                    S_SLIDE: begin
                        for (int i = 0; i < 4; i++) cells[pos[i]] <= merged[i];
                        score   <= score_next;
                        if (line_win) win <= 1'b1;
                        changed <= changed | line_diff;
                        line_q  <= line_q + 2'd1;
                        if (line_q == 2'd3) begin
                            if (changed | line_diff) begin
                                state   <= S_SPAWN;
                                probing <= 1'b0;
                            end else begin
                                state      <= S_IDLE;
                                move_ready <= 1'b1;
                                move_done  <= 1'b1;
                                moved      <= 1'b0;
                            end
                        end
                    end
                    S_CHECK: begin
                        move_done <= 1'b1;
                        moved     <= 1'b1;
                        if (full && !pair) begin
                            game_over <= 1'b1;
                            state     <= S_OVER;
                        end else begin
                            state      <= S_IDLE;
                            move_ready <= 1'b1;
                        end
                    end
                    S_OVER: begin
                        state <= S_OVER;
                    end
                    default: begin
                        state <= S_INIT;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tfe_move_ctrl.sv
// Directed bench for tfe_move_ctrl: table of moves with hand-computed boards, plus init, game-over and reset sequences.
module tb_tfe_move_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        move_valid = 1'b0;
    logic [1:0]  move_dir = 2'd0;
    logic        move_ready;
    logic        move_done;
    logic        moved;
    logic [63:0] board;
    logic [19:0] score;
    logic        game_over;
    logic        win;
`ifdef TFE_BOARD_LOAD_EN
    logic        load_valid = 1'b0;
    logic [63:0] load_board = 64'h0;
`endif

    int checks   = 0;
    int failures = 0;

    tfe_move_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .move_valid (move_valid),
        .move_dir   (move_dir),
`ifdef TFE_BOARD_LOAD_EN
        .load_valid (load_valid),
        .load_board (load_board),
`endif
        .move_ready (move_ready),
        .move_done  (move_done),
        .moved      (moved),
        .board      (board),
        .score      (score),
        .game_over  (game_over),
        .win        (win)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          do_load;
        logic [63:0] load_b;
        logic [1:0]  dir;
        logic [63:0] exp_b;
        bit          exp_moved;
        int          exp_score;
        bit          exp_win;
        bit          exp_over;
    } vec_t;

    vec_t vecs[$];

    // Rows written as 16'hC0C1C2C3 so tables read like the board.
    function automatic logic [63:0] mkb(input logic [15:0] r0, input logic [15:0] r1,
                                        input logic [15:0] r2, input logic [15:0] r3);
        logic [15:0] rows [4];
        logic [63:0] b;
        rows[0] = r0;
        rows[1] = r1;
        rows[2] = r2;
        rows[3] = r3;
        b = 64'h0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) b[(r*4+c)*4 +: 4] = rows[r][15-4*c -: 4];
        end
        return b;
    endfunction

    task automatic addVec(input bit do_load, input logic [63:0] load_b, input logic [1:0] dir,
                          input logic [63:0] exp_b, input bit exp_moved, input int exp_score,
                          input bit exp_win, input bit exp_over);
        vec_t v;
        v.do_load   = do_load;
        v.load_b    = load_b;
        v.dir       = dir;
        v.exp_b     = exp_b;
        v.exp_moved = exp_moved;
        v.exp_score = exp_score;
        v.exp_win   = exp_win;
        v.exp_over  = exp_over;
        vecs.push_back(v);
    endtask

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic checkRange(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            failures++;
            $display("[TB] FAIL %s: actual=%0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Cells differing from exp only count as a spawn when exp is empty and the DUT holds 1 or 2.
    task automatic boardDiff(input logic [63:0] act, input logic [63:0] exp, output int bad, output int spawns);
        logic [3:0] a;
        logic [3:0] e;
        bad    = 0;
        spawns = 0;
        for (int c = 0; c < 16; c++) begin
            a = act[c*4 +: 4];
            e = exp[c*4 +: 4];
            if (a != e) begin
                if (e == 4'd0 && (a == 4'd1 || a == 4'd2)) spawns++;
                else bad++;
            end
        end
    endtask

    task automatic waitReady(output int cyc, output bit ok);
        cyc = 0;
        while (!move_ready && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        ok = move_ready;
    endtask

    task automatic applyStimulus(input vec_t v, output int lat, output bit done);
        int cyc;
        bit ok;
`ifdef TFE_BOARD_LOAD_EN
        if (v.do_load) begin
            load_valid = 1'b1;
            load_board = v.load_b;
            @(posedge clk);
            #1;
            load_valid = 1'b0;
        end
`endif
        lat  = 0;
        done = 1'b0;
        waitReady(cyc, ok);
        if (!ok) return;
        move_valid = 1'b1;
        move_dir   = v.dir;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        lat = 1;
        while (!move_done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        done = move_done;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  lat;
        int  cyc;
        int  bad;
        int  sp;
        int  seen;
        bit  done;
        bit  ok;
        vec_t v;

        addVec(1'b0, 64'h0, 2'd2, mkb(16'h1100, 16'h0, 16'h0, 16'h0), 1'b0, 0, 1'b0, 1'b0);
        addVec(1'b0, 64'h0, 2'd0, mkb(16'h2000, 16'h0, 16'h0, 16'h0), 1'b1, 4, 1'b0, 1'b0);
`ifdef TFE_BOARD_LOAD_EN
        addVec(1'b1, mkb(16'h1111, 16'h0, 16'h0, 16'h0), 2'd0, mkb(16'h2200, 16'h0, 16'h0, 16'h0), 1'b1, 8, 1'b0, 1'b0);
        addVec(1'b1, mkb(16'h2110, 16'h0, 16'h0, 16'h0), 2'd1, mkb(16'h0022, 16'h0, 16'h0, 16'h0), 1'b1, 4, 1'b0, 1'b0);
        addVec(1'b1, mkb(16'h2110, 16'h0, 16'h0, 16'h0), 2'd0, mkb(16'h2200, 16'h0, 16'h0, 16'h0), 1'b1, 4, 1'b0, 1'b0);
        addVec(1'b1, mkb(16'h1200, 16'h0, 16'h0, 16'h0), 2'd0, mkb(16'h1200, 16'h0, 16'h0, 16'h0), 1'b0, 0, 1'b0, 1'b0);
        addVec(1'b1, mkb(16'h1000, 16'h1000, 16'h1000, 16'h1000), 2'd2, mkb(16'h2000, 16'h2000, 16'h0, 16'h0), 1'b1, 8, 1'b0, 1'b0);
        addVec(1'b1, mkb(16'h0300, 16'h0, 16'h0300, 16'h0100), 2'd3, mkb(16'h0, 16'h0, 16'h0400, 16'h0100), 1'b1, 16, 1'b0, 1'b0);
        addVec(1'b1, mkb(16'h4467, 16'h89AB, 16'hCDE3, 16'h3456), 2'd0, mkb(16'h5670, 16'h89AB, 16'hCDE3, 16'h3456), 1'b1, 32, 1'b0, 1'b1);
        addVec(1'b1, mkb(16'h1111, 16'h0, 16'h0, 16'h0), 2'd0, mkb(16'h2200, 16'h0, 16'h0, 16'h0), 1'b1, 8, 1'b0, 1'b0);
        addVec(1'b1, mkb(16'hAA00, 16'h0, 16'h0, 16'h0), 2'd0, mkb(16'hB000, 16'h0, 16'h0, 16'h0), 1'b1, 2048, 1'b1, 1'b0);
        addVec(1'b1, mkb(16'hFFFF, 16'h0, 16'h0, 16'h0), 2'd0, mkb(16'hFF00, 16'h0, 16'h0, 16'h0), 1'b1, 65536, 1'b0, 1'b0);
        addVec(1'b1, mkb(16'h1120, 16'h0, 16'h0, 16'h0), 2'd0, mkb(16'h2200, 16'h0, 16'h0, 16'h0), 1'b1, 4, 1'b0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_board", board, 64'h0);
        checkOutput("rst_score", score, 0);
        checkOutput("rst_ready", move_ready, 0);
        checkOutput("rst_done", move_done, 0);
        rst = 1'b0;

        // SEED 0xACE1 spawns a 1 at cell 1, then the shifted 0x5670 spawns a 1 at cell 0.
        waitReady(cyc, ok);
        checkOutput("init_ready", ok, 1);
        checkRange("init_ready_cycles", cyc, 1, 34);
        boardDiff(board, 64'h0, bad, sp);
        checkOutput("init_bad_cells", bad, 0);
        checkOutput("init_tiles", sp, 2);
        checkOutput("init_board", board, mkb(16'h1100, 16'h0, 16'h0, 16'h0));
        checkOutput("init_score", score, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            applyStimulus(v, lat, done);
            checkOutput($sformatf("v%0d_done", i), done, 1);
            if (v.exp_moved) checkRange($sformatf("v%0d_latency", i), lat, 7, 22);
            else checkOutput($sformatf("v%0d_latency", i), lat, 5);
            checkOutput($sformatf("v%0d_moved", i), moved, v.exp_moved);
            checkOutput($sformatf("v%0d_score", i), score, v.exp_score);
            checkOutput($sformatf("v%0d_win", i), win, v.exp_win);
            checkOutput($sformatf("v%0d_game_over", i), game_over, v.exp_over);
            checkOutput($sformatf("v%0d_ready", i), move_ready, !v.exp_over);
            boardDiff(board, v.exp_b, bad, sp);
            checkOutput($sformatf("v%0d_board_bad", i), bad, 0);
            checkOutput($sformatf("v%0d_spawns", i), sp, v.exp_moved ? 1 : 0);

            if (v.exp_over) begin
                move_valid = 1'b1;
                move_dir   = 2'd1;
                @(posedge clk);
                #1;
                move_valid = 1'b0;
                seen = 0;
                for (int c = 0; c < 10; c++) begin
                    if (move_done) seen++;
                    @(posedge clk);
                    #1;
                end
                checkOutput($sformatf("v%0d_over_no_done", i), seen, 0);
                checkOutput($sformatf("v%0d_over_ready", i), move_ready, 0);
                checkOutput($sformatf("v%0d_over_sticky", i), game_over, 1);
                boardDiff(board, v.exp_b, bad, sp);
                checkOutput($sformatf("v%0d_over_board_bad", i), bad, 0);
                checkOutput($sformatf("v%0d_over_spawns", i), sp, 1);
            end
        end

        // Reset in the middle of SLIDE: everything must drop to reset values at once.
`ifdef TFE_BOARD_LOAD_EN
        load_valid = 1'b1;
        load_board = mkb(16'hAA00, 16'h0, 16'h0, 16'h0);
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        move_dir   = 2'd0;
`else
        move_dir   = 2'd1;
`endif
        waitReady(cyc, ok);
        checkOutput("mid_ready", ok, 1);
        move_valid = 1'b1;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        @(posedge clk);
        #1;
`ifdef TFE_BOARD_LOAD_EN
        checkOutput("mid_win_before_rst", win, 1);
        checkOutput("mid_score_before_rst", score, 2048);
`endif
        #2;
        rst = 1'b1;
        #1;
        checkOutput("mid_rst_board", board, 64'h0);
        checkOutput("mid_rst_score", score, 0);
        checkOutput("mid_rst_win", win, 0);
        checkOutput("mid_rst_game_over", game_over, 0);
        checkOutput("mid_rst_done", move_done, 0);
        checkOutput("mid_rst_moved", moved, 0);
        checkOutput("mid_rst_ready", move_ready, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitReady(cyc, ok);
        checkOutput("reinit_ready", ok, 1);
        checkOutput("reinit_board", board, mkb(16'h1100, 16'h0, 16'h0, 16'h0));
        checkOutput("reinit_score", score, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
